segment_transition: RTL and testbench
=====================================

SEGMENT_TRANSITION -- requirements
Module: segment_transition

Interface
REQ-001 Parameter NUM_SEGMENT, default 2, number of segments (≥2); SEG_W = $clog2(NUM_SEGMENT).
REQ-002 Parameter IDX_WIDTH, default 15, width of the playback index.
REQ-003 Parameter REP_WIDTH, default 16, width of the repeat count; all-ones means infinite.
REQ-004 Parameter NUM_GPIO, default 4, number of GPIO trigger inputs.
REQ-005 CLK  in  1  system clock; single clock domain.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 UPDATE_SETTINGS  in  1  one-cycle pulse; latches a new transition request.
REQ-008 REQ_RD_SEGMENT  in  SEG_W  requested segment.
REQ-009 TRANSITION_MODE  in  8  transition_mode_t code.
REQ-010 TRANSITION_VALUE  in  64  mode argument: system-time threshold, or GPIO number in bits [1:0].
REQ-011 CYCLE  in  NUM_SEGMENT×IDX_WIDTH  last index of each segment.
REQ-012 REP  in  NUM_SEGMENT×REP_WIDTH  repeat count per segment; loops played = REP+1.
REQ-013 IDX  in  IDX_WIDTH  current playback index from the timer.
REQ-014 SYS_TIME  in  64  free-running system time.
REQ-015 GPIO_IN  in  NUM_GPIO  external trigger lines, already synchronised.
REQ-016 SEGMENT  out  SEG_W  active segment.
REQ-017 STOP  out  1  high when the active segment has finished its finite repeat count.
REQ-018 PENDING  out  1  high while a request is awaiting its trigger.

Function
REQ-019 Wrap event: IDX==0 and the previous-cycle IDX==CYCLE[SEGMENT].
REQ-020 On a wrap event with STOP low, the loop counter increments; when it reaches REP[SEGMENT], the next wrap sets STOP, unless REP is all-ones.
REQ-021 FSM states: IDLE, WAIT_SYNC, WAIT_TIME, WAIT_GPIO, EXT_RUN.
REQ-022 UPDATE_SETTINGS latches REQ_RD_SEGMENT and TRANSITION_VALUE, then enters the state for the requested mode: SYNC_IDX→WAIT_SYNC, SYS_TIME→WAIT_TIME, GPIO→WAIT_GPIO, EXT→EXT_RUN.
REQ-023 An undefined TRANSITION_MODE code is ignored: state, PENDING and latched values are unchanged.
REQ-024 WAIT_SYNC: swap on the next wrap event.
REQ-025 WAIT_TIME: swap on the first cycle where SYS_TIME ≥ the latched value; a threshold already in the past swaps on the next cycle.
REQ-026 WAIT_GPIO: swap on a rising edge of GPIO_IN[value[1:0]]; a level that is already high does not trigger.
REQ-027 A swap sets SEGMENT to the latched segment, clears the loop counter and STOP, and returns the FSM to IDLE.
REQ-028 Swap timing: SEGMENT updates one cycle after the trigger condition is sampled.
REQ-029 EXT_RUN, entry: swap immediately (1 cycle) to the latched segment and remain in EXT_RUN.
REQ-030 EXT_RUN, completion: when the active segment completes its REP+1 loops, swap to (SEGMENT+1) mod NUM_SEGMENT on the same wrap instead of setting STOP.
REQ-031 PENDING is high exactly in WAIT_SYNC, WAIT_TIME and WAIT_GPIO.
REQ-032 A new UPDATE_SETTINGS while PENDING replaces the old request; the old request never takes effect.
REQ-033 UPDATE_SETTINGS coinciding with a trigger: the new request wins and the trigger is discarded.
REQ-034 A request for the already-active segment still performs the swap, restarting the loop count.
REQ-035 In IDLE after STOP, the block holds: SEGMENT and STOP stay constant until the next request.

Reset
REQ-036 While RST_N is low: SEGMENT=0, STOP=0, PENDING=0, FSM=IDLE, loop counter=0, latched registers=0, previous-IDX and GPIO history registers=0.
REQ-037 Deasserting RST_N mid-wait discards the pending request; no swap occurs.

Structure
REQ-038 transition_mode_t codes (0x00, 0x01, 0x02, 0xF0) and the generalised NumSegment constant live in the shared params package.
REQ-039 The FSM state enum is local to this module.
REQ-040 The loop/wrap counting is one sub-module, loop_counter (inputs IDX, CYCLE, REP, clear; outputs wrap, done).

Verification
REQ-041 NUM_SEGMENT=2, CYCLE[0]=3, REP[0]=1 -> STOP rises on the second wrap (IDX 3→0) and SEGMENT stays 0.
REQ-042 SYNC_IDX request for segment 1 at IDX=1 -> PENDING=1 until IDX 3→0; SEGMENT=1 one cycle later and PENDING=0.
REQ-043 SYS_TIME request with value 1000 while SYS_TIME=990 -> swap after SYS_TIME=1000; a second run with value 500 (past) swaps on the next cycle.
REQ-044 GPIO request, value=2, with GPIO_IN[2] already high -> no swap; after low then high -> swap one cycle after the edge.
REQ-045 NUM_SEGMENT=4, EXT request for segment 2, REP all=0 -> SEGMENT cycles 2,3,0,1 on successive wraps and STOP never rises.
REQ-046 SYNC_IDX request followed by RST_N low for 1 cycle before the wrap -> SEGMENT=0, PENDING=0, and no swap at the wrap.

Source files
------------

// File: rtl/segment_transition_pkg.sv
// Shared definitions for the segment transition block: transition mode codes and the
// default segment count.
package segment_transition_pkg;

  localparam int unsigned NumSegment = 2;

  typedef enum logic [7:0] {
    ModeSyncIdx = 8'h00,
    ModeSysTime = 8'h01,
    ModeGpio    = 8'h02,
    ModeExt     = 8'hF0
  } transition_mode_t;

  function automatic logic mode_is_valid(input logic [7:0] code);
    case (code)
      ModeSyncIdx, ModeSysTime, ModeGpio, ModeExt: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segment_transition_if.sv
// Request/status bundle between the playback controller and the segment transition block.
interface segment_transition_if #(
  parameter int unsigned NUM_SEGMENT = 2,
  parameter int unsigned IDX_WIDTH   = 15,
  parameter int unsigned REP_WIDTH   = 16,
  parameter int unsigned NUM_GPIO    = 4
);
  localparam int unsigned SEG_W = $clog2(NUM_SEGMENT);

  logic                             update_settings;
  logic [SEG_W-1:0]                 req_rd_segment;
  logic [7:0]                       transition_mode;
  logic [63:0]                      transition_value;
  logic [NUM_SEGMENT*IDX_WIDTH-1:0] cycle;
  logic [NUM_SEGMENT*REP_WIDTH-1:0] rep;
  logic [IDX_WIDTH-1:0]             idx;
  logic [63:0]                      sys_time;
  logic [NUM_GPIO-1:0]              gpio_in;
  logic [SEG_W-1:0]                 segment;
  logic                             stop;
  logic                             pending;

  modport master (
    output update_settings, req_rd_segment, transition_mode, transition_value,
    output cycle, rep, idx, sys_time, gpio_in,
    input  segment, stop, pending
  );

  modport slave (
    input  update_settings, req_rd_segment, transition_mode, transition_value,
    input  cycle, rep, idx, sys_time, gpio_in,
    output segment, stop, pending
  );

endinterface

// File: rtl/segment_transition_loop_counter.sv
// Detects playback-index wraps for the active segment and counts completed loops;
// done fires on the wrap that ends the final (REP+1)th loop.
module loop_counter #(
  parameter int unsigned IDX_WIDTH = 15,
  parameter int unsigned REP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic [IDX_WIDTH-1:0] cycle_i,
  input  logic [REP_WIDTH-1:0] rep_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  output logic                 wrap_o,
  output logic                 done_o
);

  logic [IDX_WIDTH-1:0] idx_prev_q;
  logic [REP_WIDTH-1:0] count_q, count_d;

  assign wrap_o = (idx_i == '0) && (idx_prev_q == cycle_i);
  // An all-ones repeat count never completes.
  assign done_o = wrap_o && en_i && (count_q == rep_i) && (rep_i != '1);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wrap_o && en_i && !done_o) begin
      count_d = count_q + REP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_prev_q <= '0;
      count_q    <= '0;
    end else begin
      idx_prev_q <= idx_i;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/segment_transition.sv
// Switches the active playback segment on a sync-index wrap, a system-time threshold,
// a GPIO rising edge, or runs segments back to back in external sequencing mode.
module segment_transition
  import segment_transition_pkg::*;
#(
  parameter int unsigned NUM_SEGMENT = NumSegment,
  parameter int unsigned IDX_WIDTH   = 15,
  parameter int unsigned REP_WIDTH   = 16,
  parameter int unsigned NUM_GPIO    = 4
) (
  input logic                clk,
  input logic                rst_n,
  segment_transition_if.slave bus_io
);

  localparam int unsigned SEG_W = $clog2(NUM_SEGMENT);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitSync = 3'd1;
  localparam logic [2:0] StWaitTime = 3'd2;
  localparam logic [2:0] StWaitGpio = 3'd3;
  localparam logic [2:0] StExtRun   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [SEG_W-1:0]     req_seg_q, req_seg_d;
  logic [63:0]          value_q, value_d;
  logic                 stop_q, stop_d;
  logic [NUM_GPIO-1:0]  gpio_prev_q;
  logic [IDX_WIDTH-1:0] cur_cycle;
  logic [REP_WIDTH-1:0] cur_rep;
  logic [SEG_W-1:0]     seg_next;
  logic                 wrap, done, clear, swap, gpio_rise, new_req;

  assign cur_cycle = bus_io.cycle[int'(seg_q)*IDX_WIDTH +: IDX_WIDTH];
  assign cur_rep   = bus_io.rep[int'(seg_q)*REP_WIDTH +: REP_WIDTH];
  assign seg_next  = (seg_q == SEG_W'(NUM_SEGMENT - 1)) ? '0 : seg_q + SEG_W'(1);
  assign new_req   = bus_io.update_settings && mode_is_valid(bus_io.transition_mode);

  loop_counter #(
    .IDX_WIDTH(IDX_WIDTH),
    .REP_WIDTH(REP_WIDTH)
  ) u_loop_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .idx_i  (bus_io.idx),
    .cycle_i(cur_cycle),
    .rep_i  (cur_rep),
    .en_i   (!stop_q),
    .clear_i(clear),
    .wrap_o (wrap),
    .done_o (done)
  );

  always_comb begin
    gpio_rise = 1'b0;
    for (int i = 0; i < int'(NUM_GPIO); i++) begin
      if (int'(value_q[1:0]) == i) gpio_rise = bus_io.gpio_in[i] && !gpio_prev_q[i];
    end
  end

  always_comb begin
    case (state_q)
      StWaitSync: swap = wrap;
      StWaitTime: swap = (bus_io.sys_time >= value_q);
      StWaitGpio: swap = gpio_rise;
      default:    swap = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    req_seg_d = req_seg_q;
    value_d   = value_q;
    stop_d    = stop_q;
    clear     = 1'b0;

    // Loop completion: roll over in external mode, otherwise latch STOP.
    if (done) begin
      if (state_q == StExtRun && !new_req) begin
        seg_d = seg_next;
        clear = 1'b1;
      end else begin
        stop_d = 1'b1;
      end
    end

    // A fresh request always beats a trigger sampled in the same cycle.
    if (new_req) begin
      req_seg_d = bus_io.req_rd_segment;
      value_d   = bus_io.transition_value;
      case (bus_io.transition_mode)
        ModeSysTime: state_d = StWaitTime;
        ModeGpio:    state_d = StWaitGpio;
        ModeExt: begin
          state_d = StExtRun;
          seg_d   = bus_io.req_rd_segment;
          stop_d  = 1'b0;
          clear   = 1'b1;
        end
        default:     state_d = StWaitSync;
      endcase
    end else if (swap) begin
      state_d = StIdle;
      seg_d   = req_seg_q;
      stop_d  = 1'b0;
      clear   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      seg_q       <= '0;
      req_seg_q   <= '0;
      value_q     <= '0;
      stop_q      <= 1'b0;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      req_seg_q   <= req_seg_d;
      value_q     <= value_d;
      stop_q      <= stop_d;
      gpio_prev_q <= bus_io.gpio_in;
    end
  end

  assign bus_io.segment = seg_q;
  assign bus_io.stop    = stop_q;
  assign bus_io.pending = (state_q == StWaitSync) || (state_q == StWaitTime) ||
                          (state_q == StWaitGpio);

endmodule

// File: tb/tb_segment_transition.sv
// Scoreboard bench: a 2-segment instance covers the wait modes, a 4-segment instance
// covers external sequencing.
module tb_segment_transition;
  import segment_transition_pkg::*;

  localparam int unsigned IdxW  = 15;
  localparam int unsigned RepW  = 16;
  localparam int unsigned NGpio = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  segment_transition_if #(.NUM_SEGMENT(2), .IDX_WIDTH(IdxW), .REP_WIDTH(RepW),
                          .NUM_GPIO(NGpio)) bus2 ();
  segment_transition_if #(.NUM_SEGMENT(4), .IDX_WIDTH(IdxW), .REP_WIDTH(RepW),
                          .NUM_GPIO(NGpio)) bus4 ();

  segment_transition #(.NUM_SEGMENT(2), .IDX_WIDTH(IdxW), .REP_WIDTH(RepW),
                       .NUM_GPIO(NGpio)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus2.slave)
  );

  segment_transition #(.NUM_SEGMENT(4), .IDX_WIDTH(IdxW), .REP_WIDTH(RepW),
                       .NUM_GPIO(NGpio)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus4.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string       tag_q[$];
  logic [3:0]  exp_q[$];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {pend,stop,seg}=%b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] st(input logic p, input logic s, input logic [1:0] seg);
    return {p, s, seg};
  endfunction

  function automatic logic [3:0] obs2();
    return {bus2.pending, bus2.stop, 1'b0, bus2.segment};
  endfunction

  function automatic logic [3:0] obs4();
    return {bus4.pending, bus4.stop, bus4.segment};
  endfunction

  task automatic set_time(input logic [63:0] t);
    bus2.sys_time = t;
    bus4.sys_time = t;
  endtask

  task automatic set_gpio(input logic [3:0] g);
    bus2.gpio_in = g;
    bus4.gpio_in = g;
  endtask

  task automatic req2(input logic seg, input logic [7:0] mode, input logic [63:0] val);
    bus2.update_settings  = 1'b1;
    bus2.req_rd_segment   = seg;
    bus2.transition_mode  = mode;
    bus2.transition_value = val;
  endtask

  task automatic req4(input logic [1:0] seg, input logic [7:0] mode, input logic [63:0] val);
    bus4.update_settings  = 1'b1;
    bus4.req_rd_segment   = seg;
    bus4.transition_mode  = mode;
    bus4.transition_value = val;
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge status, then score it.
  task automatic drv(input string tag, input logic [IdxW-1:0] idx, input bit use4,
                     input logic [3:0] exp);
    logic [3:0] obs;
    bus2.idx = idx;
    bus4.idx = idx;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus2.update_settings = 1'b0;
    bus4.update_settings = 1'b0;
    obs = use4 ? obs4() : obs2();
    check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus2.update_settings = 1'b0;
    bus4.update_settings = 1'b0;
    bus2.idx = '0;
    bus4.idx = '0;
    set_time(64'd0);
    set_gpio(4'b0000);
    @(posedge clk);
    #1;
    check("reset_dut2", obs2(), st(0, 0, 0));
    check("reset_dut4", obs4(), st(0, 0, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    bus2.update_settings  = 1'b0;
    bus2.req_rd_segment   = '0;
    bus2.transition_mode  = '0;
    bus2.transition_value = '0;
    bus4.update_settings  = 1'b0;
    bus4.req_rd_segment   = '0;
    bus4.transition_mode  = '0;
    bus4.transition_value = '0;
    bus2.cycle = {15'd3, 15'd3};
    bus2.rep   = {16'hFFFF, 16'd1};
    bus4.cycle = {4{15'd1}};
    bus4.rep   = '0;

    // Two loops of segment 0 then STOP, held across later wraps.
    do_reset();
    for (int i = 0; i < 7; i++) drv("loop_run", IdxW'((i + 1) % 4), 0, st(0, 0, 0));
    drv("stop_rise", 15'd0, 0, st(0, 1, 0));
    for (int i = 0; i < 4; i++) drv("stop_hold", IdxW'((i + 1) % 4), 0, st(0, 1, 0));

    // Sync-index swap.
    do_reset();
    req2(1'b1, ModeSyncIdx, 64'd0);
    drv("sync_pend1", 15'd1, 0, st(1, 0, 0));
    drv("sync_pend2", 15'd2, 0, st(1, 0, 0));
    drv("sync_pend3", 15'd3, 0, st(1, 0, 0));
    drv("sync_swap", 15'd0, 0, st(0, 0, 1));
    drv("sync_after", 15'd1, 0, st(0, 0, 1));

    // System-time threshold, future then past.
    do_reset();
    set_time(64'd990);
    req2(1'b1, ModeSysTime, 64'd1000);
    drv("time_req", 15'd0, 0, st(1, 0, 0));
    for (int t = 991; t < 1000; t++) begin
      set_time(64'(t));
      drv("time_wait", 15'd0, 0, st(1, 0, 0));
    end
    set_time(64'd1000);
    drv("time_swap", 15'd0, 0, st(0, 0, 1));
    set_time(64'd1001);
    req2(1'b0, ModeSysTime, 64'd500);
    drv("past_req", 15'd0, 0, st(1, 0, 1));
    set_time(64'd1002);
    drv("past_swap", 15'd0, 0, st(0, 0, 0));

    // GPIO edge: an already-high level and other lines do not trigger.
    do_reset();
    set_gpio(4'b0100);
    drv("gpio_pre", 15'd0, 0, st(0, 0, 0));
    req2(1'b1, ModeGpio, 64'd2);
    drv("gpio_req", 15'd0, 0, st(1, 0, 0));
    for (int i = 0; i < 3; i++) drv("gpio_level", 15'd0, 0, st(1, 0, 0));
    set_gpio(4'b0010);
    drv("gpio_other", 15'd0, 0, st(1, 0, 0));
    set_gpio(4'b0110);
    drv("gpio_swap", 15'd0, 0, st(0, 0, 1));

    // Replacement, trigger collision, undefined codes.
    do_reset();
    req2(1'b1, ModeSyncIdx, 64'd0);
    drv("repl_sync", 15'd1, 0, st(1, 0, 0));
    drv("repl_w2", 15'd2, 0, st(1, 0, 0));
    drv("repl_w3", 15'd3, 0, st(1, 0, 0));
    req2(1'b1, ModeSysTime, '1);
    drv("collide", 15'd0, 0, st(1, 0, 0));
    drv("repl_hold", 15'd1, 0, st(1, 0, 0));
    req2(1'b0, 8'h55, 64'd0);
    drv("bad_code", 15'd2, 0, st(1, 0, 0));
    drv("bad_keep", 15'd3, 0, st(1, 0, 0));
    drv("stop_pend", 15'd0, 0, st(1, 1, 0));
    req2(1'b1, ModeSysTime, 64'd0);
    drv("new_time", 15'd1, 0, st(1, 1, 0));
    drv("new_swap", 15'd2, 0, st(0, 0, 1));
    req2(1'b0, 8'h03, 64'd0);
    drv("bad_idle", 15'd3, 0, st(0, 0, 1));
    drv("rep_inf", 15'd0, 0, st(0, 0, 1));

    // Reset mid-wait drops the request.
    do_reset();
    req2(1'b1, ModeSyncIdx, 64'd0);
    drv("rst_w1", 15'd1, 0, st(1, 0, 0));
    drv("rst_w2", 15'd2, 0, st(1, 0, 0));
    rst_n = 1'b0;
    drv("rst_mid", 15'd3, 0, st(0, 0, 0));
    rst_n = 1'b1;
    drv("rst_post3", 15'd3, 0, st(0, 0, 0));
    drv("rst_nowrap", 15'd0, 0, st(0, 0, 0));

    // Same-segment request restarts the loop count.
    do_reset();
    for (int i = 0; i < 4; i++) drv("same_loop1", IdxW'((i + 1) % 4), 0, st(0, 0, 0));
    req2(1'b0, ModeSysTime, 64'd0);
    drv("same_req", 15'd1, 0, st(1, 0, 0));
    drv("same_swap", 15'd2, 0, st(0, 0, 0));
    drv("same_w3", 15'd3, 0, st(0, 0, 0));
    drv("same_wrap1", 15'd0, 0, st(0, 0, 0));
    for (int i = 0; i < 3; i++) drv("same_run", IdxW'(i + 1), 0, st(0, 0, 0));
    drv("same_stop", 15'd0, 0, st(0, 1, 0));

    // External sequencing on the 4-segment instance.
    do_reset();
    req4(2'd2, ModeExt, 64'd0);
    drv("ext_entry", 15'd0, 1, st(0, 0, 2));
    drv("ext_s2", 15'd1, 1, st(0, 0, 2));
    drv("ext_to3", 15'd0, 1, st(0, 0, 3));
    drv("ext_s3", 15'd1, 1, st(0, 0, 3));
    drv("ext_to0", 15'd0, 1, st(0, 0, 0));
    drv("ext_s0", 15'd1, 1, st(0, 0, 0));
    drv("ext_to1", 15'd0, 1, st(0, 0, 1));
    drv("ext_s1", 15'd1, 1, st(0, 0, 1));
    drv("ext_to2", 15'd0, 1, st(0, 0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
